// File: rtl/cam_pkg.sv
// rtl/cam_pkg.sv - shared CAM encodings, widths and masked-match function
package cam_pkg;

    localparam int DW        = 32;
    localparam int KW        = DW - 1;
    localparam int VALID_BIT = DW - 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    typedef logic [DW-1:0] word_t;
    typedef logic [KW-1:0] key_t;

    // Entry must be valid; only mask bits set to 1 take part in the compare.
    function automatic logic cam_match(input word_t word, input key_t key, input key_t mask);
        return word[VALID_BIT] && (((word[KW-1:0] ^ key) & mask) == '0);
    endfunction

endpackage

// File: rtl/cam_scan_reader_if.sv
// rtl/cam_scan_reader_if.sv - lookup request/response handshake bundle
interface cam_scan_reader_if
    import cam_pkg::*;
#(
    parameter int DPW = 10
);
    logic           req_valid;
    logic           req_ready;
    key_t           req_key;
    key_t           req_mask;
    logic           rsp_valid;
    logic           rsp_ready;
    logic           rsp_hit;
    logic [DPW-1:0] rsp_idx;

    modport master (
        output req_valid, req_key, req_mask, rsp_ready,
        input  req_ready, rsp_valid, rsp_hit, rsp_idx
    );

    modport slave (
        input  req_valid, req_key, req_mask, rsp_ready,
        output req_ready, rsp_valid, rsp_hit, rsp_idx
    );
endinterface

// File: rtl/cam_match_cmp.sv
// rtl/cam_match_cmp.sv - combinational masked key compare with entry-valid check
module cam_match_cmp
    import cam_pkg::*;
(
    input  word_t i_word,
    input  key_t  i_key,
    input  key_t  i_mask,
    output logic  o_hit
);
    assign o_hit = cam_match(i_word, i_key, i_mask);
endmodule

// File: rtl/cam_scan_reader.sv
// rtl/cam_scan_reader.sv - linear scan of the CAM RAM read port, lowest-index match
module cam_scan_reader
    import cam_pkg::*;
#(
    parameter int DPW = 10
)(
    input  logic            clk,
    input  logic            rst_n,
    cam_scan_reader_if.slave bus,
    output logic [DPW-1:0]  ram_addr,
    input  word_t           ram_dout,
    output logic            busy
);
    localparam logic [DPW-1:0] LAST_IDX = '1;

    logic [1:0]     r_state;
    key_t           r_key;
    key_t           r_mask;
    logic [DPW-1:0] r_addr;
    logic           r_iss_v;
    logic           r_trk_v;
    logic [DPW-1:0] r_trk_idx;
    logic           r_hit;
    logic [DPW-1:0] r_idx;
    logic           w_match;

    cam_match_cmp u_cmp (
        .i_word (ram_dout),
        .i_key  (r_key),
        .i_mask (r_mask),
        .o_hit  (w_match)
    );

    // {r_iss_v, r_addr} is the issue stage, {r_trk_v, r_trk_idx} lines up with ram_dout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_key     <= '0;
            r_mask    <= '0;
            r_addr    <= '0;
            r_iss_v   <= 1'b0;
            r_trk_v   <= 1'b0;
            r_trk_idx <= '0;
            r_hit     <= 1'b0;
            r_idx     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        r_key   <= bus.req_key;
                        r_mask  <= bus.req_mask;
                        r_addr  <= '0;
                        r_iss_v <= 1'b1;
                        r_trk_v <= 1'b0;
                        r_state <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (r_iss_v) begin
                        if (r_addr != LAST_IDX) r_addr <= r_addr + 1'b1;
                        else                    r_iss_v <= 1'b0;
                    end
                    r_trk_v   <= r_iss_v;
                    r_trk_idx <= r_addr;
                    if (r_trk_v && w_match) begin
                        r_hit   <= 1'b1;
                        r_idx   <= r_trk_idx;
                        r_iss_v <= 1'b0;
                        r_trk_v <= 1'b0;
                        r_state <= ST_RESP;
                    end else if (r_trk_v && (r_trk_idx == LAST_IDX)) begin
                        r_hit   <= 1'b0;
                        r_idx   <= '0;
                        r_iss_v <= 1'b0;
                        r_trk_v <= 1'b0;
                        r_state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready = (r_state == ST_IDLE);
    assign bus.rsp_valid = (r_state == ST_RESP);
    assign bus.rsp_hit   = r_hit;
    assign bus.rsp_idx   = r_idx;
    assign ram_addr      = r_addr;
    assign busy          = (r_state != ST_IDLE);

endmodule

// File: doc/cam_scan_reader.md
# cam_scan_reader

Search engine for the CAM table's read side. It accepts one key-lookup request at a time and walks the dual-port RAM's read-only port, one address per clock. It compares every returned word against a masked key and reports the lowest matching index, or a miss, through a valid/ready response. Table writes stay on the RAM's other port and are owned by the table-update logic. This block never writes.

## Interface
- DPW, 10, RAM address width; table depth N = 2**DPW entries
- DW, 32, RAM word width; bit DW-1 = entry valid flag, bits DW-2:0 = entry key (KW = DW-1)
- clk  in  1  single clock for the block and the RAM read port
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  lookup request present
- req_ready  out  1  engine idle, request accepted when req_valid & req_ready
- req_key  in  KW  key to search
- req_mask  in  KW  compare mask; 1 = bit participates
- rsp_valid  out  1  result present
- rsp_ready  in  1  consumer takes result
- rsp_hit  out  1  1 = match found
- rsp_idx  out  DPW  lowest matching index; 0 on miss
- ram_addr  out  DPW  registered address to RAM read port (addra)
- ram_dout  in  DW  RAM read data (douta), registered in RAM, 1-cycle latency
- busy  out  1  high in SCAN or RESP

## Operation
- States: IDLE, SCAN, RESP. req_ready = (state==IDLE). busy = !IDLE.
- IDLE, accept:
  - latch req_key and req_mask
  - ram_addr <= 0
  - clear the pending-read tracker
  - go to SCAN
- SCAN, address issue: ram_addr increments by 1 each clock until it reaches N-1, then holds. No wrap.
- Pending-read tracker: a 2-stage shift of {valid, index} follows each issued address. It aligns ram_dout with the index it belongs to.
- Match rule, applied when a tracked read returns:
  - ram_dout[DW-1] == 1
  - ((ram_dout[KW-1:0] ^ key) & mask) == 0
- First match:
  - rsp_hit <= 1, rsp_idx <= index
  - go to RESP
  - discard any reads still in flight
- Index N-1 returns without a match: rsp_hit <= 0, rsp_idx <= 0, go to RESP.
- RESP:
  - rsp_valid = 1, and rsp_hit/rsp_idx hold stable until rsp_valid & rsp_ready
  - then go to IDLE
- req_valid is ignored outside IDLE.
- Multiple matches: only the lowest index is reported.
- req_mask all zeros matches the first valid entry. Valid flag still required.
- Concurrent writes on the RAM write port: no forwarding. Each read returns RAM content as of its read edge. A same-edge write to the address being read returns the old word.

## Timing
- Reset (async assert, sync release) values:
  - state IDLE, req_ready 1
  - rsp_valid 0, rsp_hit 0, rsp_idx 0
  - ram_addr 0, busy 0
  - tracker cleared
- Accept at edge E0: entry i is compared at edge E(i+2).
- Hit on entry i: rsp_valid high after edge E(i+2), i.e. i+2 cycles after accept.
- Miss: rsp_valid high after edge E(N+1).
- rsp_ready high in the first RESP cycle: req_ready high in the next cycle. Minimum gap between accepts is latency + 1 cycle.
- Reset asserted mid-SCAN or mid-RESP: outputs return to reset values immediately. The pending result is lost and no response is emitted.

## Structure
- Shared package cam_pkg holds:
  - state encodings (IDLE=2'd0, SCAN=2'd1, RESP=2'd2)
  - VALID_BIT = DW-1 and KW = DW-1
  - the shared match function, also used by the table-update logic
- One sub-module is natural: cam_match_cmp, combinational masked compare plus valid check, producing hit.
- Expected size about 150–250 lines.

## Test plan
Bench uses DPW=4, DW=32, driving the real RAM with all entries zeroed unless noted.
- Exact-key hit: entry5=32'h8000_1234; key 31'h1234, mask all ones -> rsp_hit=1, rsp_idx=5, rsp_valid 7 cycles after accept.
- Miss on empty table: any key -> rsp_hit=0, rsp_idx=0, rsp_valid 17 cycles after accept.
- Valid flag and priority: entry3=32'h0000_1234 (invalid), entry9=32'h8000_1234, entry12=32'h8000_1234 -> idx=9.
- Mask compare: entry2=32'h8000_12FF; key 31'h1200, mask 31'h7FFF_FF00 -> hit, idx=2. Same key with mask all ones -> miss.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid.
  - rsp_hit/rsp_idx stay stable and req_ready stays 0.
  - A req_valid pulse during this window is not accepted.
  - Release rsp_ready -> req_ready=1 on the next cycle.
- Reset mid-scan: assert rst_n=0 three cycles after accept -> all outputs at reset values within the same cycle, no rsp_valid after release. A new lookup then completes normally.
